// File: rtl/capture_pkg.sv
// Shared definitions for the sample capture controller: FSM encoding and
// the reload values of the min/max accumulator.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

    localparam logic [7:0] ACC_MAX_INIT = 8'h00;
    localparam logic [7:0] ACC_MIN_INIT = 8'hFF;

    function automatic logic is_busy(input cap_state_e s);
        return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/peak_accum.sv
// Unsigned running max/min of an 8-bit sample stream. The result already
// folds in the current input sample, so a strobe cycle's sample is included.
module peak_accum
    import capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        sample,
    input  logic [7:0]  din,
    output logic [15:0] result
);

    logic [7:0] max_q, max_d, min_q, min_d;
    logic [7:0] fold_max, fold_min;

    always_comb begin
        fold_max = (din > max_q) ? din : max_q;
        fold_min = (din < min_q) ? din : min_q;
        max_d    = max_q;
        min_d    = min_q;
        // Clear wins over sample: the new window starts on the following cycle.
        if (clear) begin
            max_d = ACC_MAX_INIT;
            min_d = ACC_MIN_INIT;
        end else if (sample) begin
            max_d = fold_max;
            min_d = fold_min;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= ACC_MAX_INIT;
            min_q <= ACC_MIN_INIT;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign result = {fold_max, fold_min};

endmodule

// File: rtl/sample_capture_ctrl.sv
// Pre/post-trigger capture controller: turns decimation strobes into RAM
// writes, tracks the trigger address and sequences IDLE/FILL/ARMED/POST/DONE.
module sample_capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        ADC_DATA,
    input  logic              CLK_EN,
    input  logic              PEAK_MODE,
    input  logic              START,
    input  logic              TRIG,
    input  logic [ADDR_W-1:0] PRE_CNT,
    input  logic [ADDR_W-1:0] POST_CNT,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [15:0]       WR_DATA,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic              BUSY,
    output logic              DONE
);

    cap_state_e        state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic              peak_q, peak_d;

    logic              strobe;
    logic              acc_clr;
    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       acc_result;

    peak_accum u_peak (
        .clk    (CLK),
        .rst_n  (RST),
        .clear  (acc_clr),
        .sample (busy_q),
        .din    (ADC_DATA),
        .result (acc_result)
    );

    // Address the next issued write will use: a write in flight this cycle
    // still owns WR_ADDR, so the next one lands one higher.
    assign next_addr = wr_addr_q + ADDR_W'(wr_en_q);

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_d      = post_q;
        peak_d      = peak_q;
        strobe      = 1'b0;
        acc_clr     = 1'b0;

        if (wr_en_q) wr_addr_d = wr_addr_q + ADDR_W'(1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    peak_d    = PEAK_MODE;
                    pre_d     = PRE_CNT;
                    post_d    = POST_CNT;
                    wr_addr_d = '0;
                    cnt_d     = '0;
                    acc_clr   = 1'b1;
                    state_d   = (PRE_CNT == '0) ? ST_ARMED : ST_FILL;
                end
            end
            ST_FILL: begin
                strobe = CLK_EN;
                if (CLK_EN) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if ((cnt_q + ADDR_W'(1)) == pre_q) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (TRIG) begin
                    trig_addr_d = next_addr;
                    if (post_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // A strobe coinciding with the trigger is the first post write.
                        strobe  = CLK_EN;
                        cnt_d   = CLK_EN ? ADDR_W'(1) : '0;
                        state_d = ST_POST;
                    end
                end else begin
                    strobe = CLK_EN;
                end
            end
            ST_POST: begin
                strobe = CLK_EN && (cnt_q != post_q);
                if (strobe) cnt_d = cnt_q + ADDR_W'(1);
                if ((cnt_q == post_q) && wr_en_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (strobe) begin
            wr_en_d   = 1'b1;
            wr_data_d = peak_q ? acc_result : {ADC_DATA, ADC_DATA};
            acc_clr   = 1'b1;
        end

        busy_d = is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            peak_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_addr_q <= trig_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            peak_q      <= peak_d;
        end
    end

    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign TRIG_ADDR = trig_addr_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Directed bench for sample_capture_ctrl: a 15-bit instance for the main
// scenarios and a 4-bit instance for address wrap.
module tb_sample_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  adc = '0;
    logic        clk_en = 0, peak = 0, start = 0, trig = 0;
    logic [14:0] pre = '0, post = '0;
    logic        wr_en, busy, done;
    logic [14:0] wr_addr, trig_addr;
    logic [15:0] wr_data;

    logic        clk_en4 = 0, start4 = 0, trig4 = 0;
    logic [3:0]  pre4 = '0, post4 = '0;
    logic        wr_en4, busy4, done4;
    logic [3:0]  wr_addr4, trig_addr4;
    logic [15:0] wr_data4;

    sample_capture_ctrl #(.ADDR_W(15)) u_dut (
        .CLK(clk), .RST(rst_n), .ADC_DATA(adc), .CLK_EN(clk_en), .PEAK_MODE(peak),
        .START(start), .TRIG(trig), .PRE_CNT(pre), .POST_CNT(post),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .TRIG_ADDR(trig_addr),
        .BUSY(busy), .DONE(done)
    );

    sample_capture_ctrl #(.ADDR_W(4)) u_dut4 (
        .CLK(clk), .RST(rst_n), .ADC_DATA(adc), .CLK_EN(clk_en4), .PEAK_MODE(1'b0),
        .START(start4), .TRIG(trig4), .PRE_CNT(pre4), .POST_CNT(post4),
        .WR_EN(wr_en4), .WR_ADDR(wr_addr4), .WR_DATA(wr_data4), .TRIG_ADDR(trig_addr4),
        .BUSY(busy4), .DONE(done4)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cyc = -1;
    logic done_prev = 1'b0;
    int wa[$], wd[$], wc[$];
    int wa4[$], wc4[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
        end
        if (wr_en4) begin
            wa4.push_back(int'(wr_addr4));
            wc4.push_back(cyc);
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] a, input logic en, input logic tr);
        adc    = a;
        clk_en = en;
        trig   = tr;
        @(posedge clk);
        #1;
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    bit trig_sent;
    bit tr;
    int gaps;
    int nlog;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        chk("idle_no_write", wa.size(), 0);

        // Plain mode, PRE=2, POST=3, strobe every 4th cycle, trigger after 3rd write
        peak = 0; pre = 15'd2; post = 15'd3; start = 1;
        step(8'h00, 1'b0, 1'b0);
        start = 0;
        trig_sent = 0;
        for (int i = 0; i < 120 && !done; i++) begin
            tr = (wa.size() == 3) && !trig_sent;
            if (tr) trig_sent = 1;
            step(8'h10 + 8'(i), (i % 4) == 3, tr);
        end
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_nwr", wa.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_addr%0d", k), qget(wa, k), k);
            chk($sformatf("t1_data%0d", k), qget(wd, k), {16'h0, 8'h13 + 8'(4 * k), 8'h13 + 8'(4 * k)});
        end
        chk("t1_trig_addr", trig_addr, 3);
        repeat (6) step(8'h55, 1'b1, 1'b1);
        chk("t1_done_lat", done_cyc, qget(wc, 5) + 1);
        chk("t1_hold_nwr", wa.size(), 6);
        chk("t1_hold_addr", wr_addr, 6);
        chk("t1_hold_taddr", trig_addr, 3);

        // Peak mode windows; trigger and strobe in the same ARMED cycle
        wa.delete(); wd.delete(); wc.delete();
        peak = 1; pre = 15'd2; post = 15'd1; start = 1;
        step(8'h00, 1'b0, 1'b0);
        start = 0; peak = 0;
        step(8'd10, 1'b0, 1'b0);
        step(8'd50, 1'b0, 1'b0);
        step(8'd5, 1'b0, 1'b0);
        step(8'd30, 1'b1, 1'b0);
        step(8'd200, 1'b0, 1'b0);
        step(8'd100, 1'b0, 1'b0);
        step(8'd150, 1'b1, 1'b0);
        step(8'd77, 1'b1, 1'b1);
        step(8'd0, 1'b0, 1'b0);
        step(8'd0, 1'b0, 1'b0);
        chk("t2_nwr", wa.size(), 3);
        chk("t2_addr0", qget(wa, 0), 0);
        chk("t2_peak0", qget(wd, 0), 32'h3205);
        chk("t2_peak1", qget(wd, 1), 32'hC864);
        chk("t2_peak2", qget(wd, 2), 32'h4D4D);
        chk("t2_trig_addr", trig_addr, 2);
        chk("t2_trig_wr_addr", qget(wa, 2), 32'(trig_addr));
        chk("t2_done", done, 1);

        // 4-bit address wrap, continuous strobes, TRIG held high from START
        start4 = 1; pre4 = 4'd14; post4 = 4'd4; clk_en4 = 1; trig4 = 1;
        @(posedge clk);
        #1;
        start4 = 0;
        for (int i = 0; i < 60 && !done4; i++) begin
            @(posedge clk);
            #1;
        end
        clk_en4 = 0; trig4 = 0;
        chk("t3_done", done4, 1);
        chk("t3_nwr", wa4.size(), 18);
        chk("t3_trig_addr", trig_addr4, 14);
        chk("t3_post0", qget(wa4, 14), 14);
        chk("t3_post1", qget(wa4, 15), 15);
        chk("t3_post2", qget(wa4, 16), 0);
        chk("t3_post3", qget(wa4, 17), 1);
        gaps = 0;
        for (int k = 1; k < wa4.size(); k++) begin
            if (wc4[k] != wc4[k-1] + 1) gaps++;
            if (wa4[k] != ((k % 16))) gaps++;
        end
        chk("t3_gaps", gaps, 0);
        chk("t3_wr_addr", wr_addr4, 2);

        // Reset asserted mid-capture while a POST write is on the bus
        pre = 15'd1; post = 15'd5; start = 1;
        step(8'h00, 1'b0, 1'b0);
        start = 0;
        step(8'h21, 1'b1, 1'b0);
        step(8'h22, 1'b0, 1'b1);
        step(8'h23, 1'b1, 1'b0);
        chk("t4_pre_wr_en", wr_en, 1);
        nlog = wa.size();
        rst_n = 1'b0;
        #1;
        chk("t4_wr_en", wr_en, 0);
        chk("t4_wr_addr", wr_addr, 0);
        chk("t4_wr_data", wr_data, 0);
        chk("t4_trig_addr", trig_addr, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) step(8'h44, 1'b1, 1'b1);
        chk("t4_no_writes", wa.size(), nlog);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_addr", wr_addr, 0);

        // PRE=0, POST=0: ARMED right after START, START ignored while busy
        wa.delete(); wd.delete(); wc.delete();
        pre = 15'd0; post = 15'd0; start = 1;
        step(8'h00, 1'b0, 1'b0);
        start = 0;
        chk("t5_busy", busy, 1);
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        pre = 15'd3; post = 15'd3; start = 1;
        step(8'h05, 1'b0, 1'b0);
        start = 0; pre = 15'd0; post = 15'd0;
        chk("t5_start_ign_busy", busy, 1);
        chk("t5_start_ign_addr", wr_addr, 2);
        step(8'h06, 1'b1, 1'b1);
        chk("t5_done", done, 1);
        chk("t5_busy_off", busy, 0);
        chk("t5_trig_addr", trig_addr, 2);
        repeat (3) step(8'h07, 1'b1, 1'b0);
        chk("t5_nwr", wa.size(), 2);
        chk("t5_wr_addr", wr_addr, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
